// File: rtl/uart_tx_queue_if.sv
// Byte path between the upstream producer, the transmit queue and the serializer.
// The queue is the slave; the driving environment is the master.
interface uart_tx_queue_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_start;
  logic             tx_idle;

  modport master (
    output in_data, in_valid, tx_idle,
    input  tx_data, tx_start
  );

  modport slave (
    input  in_data, in_valid, tx_idle,
    output tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Circular byte queue feeding a UART serializer: one byte is launched per
// tx_start pulse and popped only once the serializer has gone busy and returned idle.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     clr,
  uart_tx_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              ovf;
  logic              push;
  logic              pop;
  logic              drop;

  assign full     = (cnt == CNT_FULL);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign overflow = ovf;

  // A pop retires the byte the serializer has just finished; a full queue can
  // still take a push in that same cycle because a slot frees up.
  assign pop  = (state == WAIT_DONE) && bus.tx_idle && !clr;
  assign push = bus.in_valid && (!full || pop) && !clr;
  assign drop = bus.in_valid && full && !pop && !clr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) ovf    <= 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; it maps onto plain RAM and
  // stale contents are never visible because tx_data is masked while empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty && bus.tx_idle) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!bus.tx_idle) state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.tx_idle) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    // A flush abandons any byte in flight; the serializer completes it alone.
    if (clr) state_nxt = IDLE;
  end

  assign bus.tx_start = (state == LAUNCH);
  assign bus.tx_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: accepted pushes are queued as expected
// bytes and compared against tx_data on every tx_start pulse.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          clr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;

  uart_tx_queue_if #(.WIDTH(WIDTH)) bus ();

  uart_tx_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr      (clr),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 CLK = ~CLK;

  int         n_checks   = 0;
  int         n_pass     = 0;
  logic [7:0] sb [$];
  int         sent_total = 0;
  int         cyc        = 0;
  int         last_start = -100;
  bit         prev_start = 1'b0;
  bit         ser_auto   = 1'b0;
  int         busy_len   = 2;
  int         ser_cnt    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Output monitor: every launch must carry the oldest outstanding byte.
  always @(negedge CLK) begin
    logic [7:0] exp_byte;
    cyc++;
    if (bus.tx_start) begin
      check("start_single", 32'(prev_start), 0);
      check("start_gap_ge4", 32'((cyc - last_start) >= 4), 1);
      check("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_byte = sb.pop_front();
        check("tx_data", 32'(bus.tx_data), 32'(exp_byte));
      end
      sent_total++;
      last_start = cyc;
    end
    prev_start = bus.tx_start;
  end

  // One clock of stimulus; optionally emulates a serializer that drops idle
  // on seeing tx_start and raises it busy_len cycles later.
  task automatic tick(input bit v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    if (ser_auto) begin
      if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) bus.tx_idle = 1'b1;
      end else if (bus.tx_start) begin
        bus.tx_idle = 1'b0;
        ser_cnt     = busy_len;
      end
    end
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    if (accept) sb.push_back(d);
    tick(1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask

  task automatic drain(input int budget, input string tag);
    int k = 0;
    while (!empty && k < budget) begin
      tick(1'b0, 8'h00);
      k++;
    end
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_sb_left"}, 32'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    RST_N        = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.tx_idle  = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_start", 32'(bus.tx_start), 0);
    check("rst_data", 32'(bus.tx_data), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Single byte: two-cycle launch latency, then a ten-cycle busy serializer.
    ser_auto = 1'b1;
    busy_len = 10;
    n0 = sent_total;
    push(8'h41, 1'b1);
    check("lat_cycle1_start", 32'(bus.tx_start), 0);
    check("lat_cycle1_count", 32'(count), 1);
    tick(1'b0, 8'h00);
    check("lat_cycle2_start", 32'(bus.tx_start), 1);
    check("lat_cycle2_data", 32'(bus.tx_data), 32'h41);
    drain(40, "single");
    check("single_sent", 32'(sent_total - n0), 1);

    // Fill while the serializer is busy, then overflow with 0xAA.
    ser_auto    = 1'b0;
    bus.tx_idle = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b1);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), DEPTH);
    check("fill_ovf", 32'(overflow), 0);
    push(8'hAA, 1'b0);
    check("drop_ovf", 32'(overflow), 1);
    check("drop_count", 32'(count), DEPTH);
    check("drop_full", 32'(full), 1);

    // Launch the head, then push 0x55 in the cycle the serializer returns idle.
    bus.tx_idle = 1'b1;
    tick(1'b0, 8'h00);
    check("full_launch", 32'(bus.tx_start), 1);
    bus.tx_idle = 1'b0;
    idle(3);
    check("wait_done_count", 32'(count), DEPTH);
    bus.tx_idle = 1'b1;
    push(8'h55, 1'b1);
    check("pushpop_count", 32'(count), DEPTH);
    check("pushpop_full", 32'(full), 1);
    check("ovf_sticky", 32'(overflow), 1);
    ser_auto = 1'b1;
    busy_len = 2;
    ser_cnt  = 0;
    drain(600, "fulldrain");

    // Twenty bytes with irregular gaps, crossing the pointer wrap.
    n0 = sent_total;
    for (int i = 0; i < 20; i++) begin
      push(8'h80 + 8'(i), 1'b1);
      idle($urandom_range(0, 3));
    end
    drain(400, "mixed");
    check("mixed_sent", 32'(sent_total - n0), 20);

    // Flush during WAIT_DONE with five entries; a push in the flush cycle is lost.
    ser_auto    = 1'b0;
    bus.tx_idle = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1'b1);
    bus.tx_idle = 1'b1;
    tick(1'b0, 8'h00);
    check("clr_launch", 32'(bus.tx_start), 1);
    bus.tx_idle = 1'b0;
    idle(2);
    check("clr_pre_count", 32'(count), 5);
    check("clr_pre_ovf", 32'(overflow), 1);
    clr = 1'b1;
    tick(1'b1, 8'h77);
    clr = 1'b0;
    sb.delete();
    check("clr_count", 32'(count), 0);
    check("clr_empty", 32'(empty), 1);
    check("clr_ovf", 32'(overflow), 0);
    check("clr_start", 32'(bus.tx_start), 0);
    check("clr_data", 32'(bus.tx_data), 0);
    n0 = sent_total;
    bus.tx_idle = 1'b1;
    idle(20);
    check("clr_no_start", 32'(sent_total - n0), 0);
    check("clr_still_empty", 32'(empty), 1);

    // Asynchronous reset while in WAIT_BUSY.
    bus.tx_idle = 1'b0;
    for (int i = 0; i < 3; i++) push(8'h21 + 8'(i), 1'b1);
    bus.tx_idle = 1'b1;
    tick(1'b0, 8'h00);
    check("rst_mid_launch", 32'(bus.tx_start), 1);
    tick(1'b0, 8'h00);
    #2 RST_N = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_full", 32'(full), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_start", 32'(bus.tx_start), 0);
    check("arst_data", 32'(bus.tx_data), 0);
    sb.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    ser_auto = 1'b1;
    ser_cnt  = 0;
    n0 = sent_total;
    push(8'h5A, 1'b1);
    drain(40, "post_rst");
    check("post_rst_sent", 32'(sent_total - n0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter WIDTH, default 8, byte width per entry.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_data  input  WIDTH  byte from the upstream stage.
REQ-006 SHALL have port in_valid  input  1  one-cycle push strobe qualifying in_data.
REQ-007 SHALL have port clr  input  1  synchronous flush of the queue.
REQ-008 SHALL have port tx_data  output  WIDTH  byte presented to the downstream serializer.
REQ-009 SHALL have port tx_start  output  1  one-cycle launch pulse to the serializer.
REQ-010 SHALL have port tx_idle  input  1  serializer idle level (high = ready for a byte).
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port overflow  output  1  sticky flag for a dropped push.

Function
REQ-015 SHALL store pushed bytes in a DEPTH-entry circular buffer with read and write pointers that wrap modulo DEPTH.
REQ-016 SHALL accept a push when in_valid=1 and (full=0, or a pop occurs in the same cycle).
REQ-017 SHALL drop a push when in_valid=1, full=1 and no pop occurs that cycle; overflow then goes to 1, and pointers and count stay unchanged.
REQ-018 SHALL leave count unchanged on a simultaneous accepted push and pop.
REQ-019 SHALL use the FSM states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-020 SHALL in IDLE: go to LAUNCH when empty=0 and tx_idle=1; otherwise stay.
REQ-021 SHALL in LAUNCH: assert tx_start=1 for exactly this one cycle, then go to WAIT_BUSY.
REQ-022 SHALL in WAIT_BUSY: go to WAIT_DONE when tx_idle=0; otherwise stay.
REQ-023 SHALL in WAIT_DONE: when tx_idle=1, pop the head entry (advance the read pointer) and go to IDLE.
REQ-024 SHALL drive tx_data from the head entry at all times, unchanged from LAUNCH through the pop.
REQ-025 SHALL give latency from push into an empty queue (tx_idle=1) to tx_start of 2 cycles (push edge, IDLE->LAUNCH edge).
REQ-026 SHALL allow a minimum of 4 cycles between consecutive tx_start pulses.
REQ-027 SHALL on clr=1 empty the queue, zero both pointers and count, clear overflow, force the FSM to IDLE and tx_start to 0, and drop any push in that cycle.
REQ-028 SHALL give clr priority over push and pop.
REQ-029 SHALL not pop the byte in flight when clr occurs in WAIT_BUSY or WAIT_DONE; the byte is discarded, and the serializer finishes it independently.
REQ-030 SHALL keep tx_start from asserting outside LAUNCH.

Reset
REQ-031 SHALL apply the following when RST_N=0, asynchronously: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=0.
REQ-032 SHALL leave buffer storage contents unreset; tx_data reads 0 via an output mux while empty=1.
REQ-033 SHALL resume normal operation on the first rising CLK edge after RST_N deasserts.
REQ-034 SHALL on reset assertion mid-transfer (any non-IDLE state) discard all entries and not complete the pending pop.

Verification
REQ-035 SHALL be verified with: single push 0x41 with tx_idle=1 -> tx_start pulses 2 cycles later with tx_data=0x41; the bench drops tx_idle 1 cycle later and raises it 10 cycles after that -> count returns to 0 and empty=1.
REQ-036 SHALL be verified with: push 0x00..0x0F back-to-back with tx_idle held 0 -> full=1, count=16; a 17th push 0xAA -> overflow=1, count=16, 0xAA never sent.
REQ-037 SHALL be verified with: full queue, push 0x55 in the WAIT_DONE cycle where tx_idle rises -> push accepted, count stays 16, 0x55 sent last.
REQ-038 SHALL be verified with: 20 bytes with mixed pushes/pops crossing the pointer wrap -> output order equals input order and no byte is duplicated or lost.
REQ-039 SHALL be verified with: clr during WAIT_DONE with 5 entries -> next cycle count=0, FSM=IDLE, overflow=0, and no further tx_start.
REQ-040 SHALL be verified with: RST_N pulsed low mid-cycle in WAIT_BUSY -> all outputs at reset values immediately, without waiting for a CLK edge.
